// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control block.
// The optional performance counters are enabled with PIPE_CTRL_PERF_EN.
package pipe_pkg;

   localparam int PERF_CNT_W = 32;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      REDIR_WAIT = 2'd1,
      TRAP_WAIT  = 2'd2
   } ctrl_state_t;

   // Stall/clear controls for every pipeline boundary (PC, IF/ID, ID/EX, EX/MA, MA/WB)
   typedef struct packed {
      logic stall_pc;
      logic stall_fd;
      logic stall_de;
      logic stall_em;
      logic clear_fd;
      logic clear_de;
      logic clear_em;
      logic clear_mw;
   } pipe_ctl_t;

   // Saturating increment used by the performance counters
   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                     input logic en);
      if (en && (v != {PERF_CNT_W{1'b1}}))
         return v + 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard sources, control-flow events and generated stall/clear
// outputs between the core datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(parameter int NREG = 5);
   import pipe_pkg::*;

   logic [NREG-1:0]       id_rs1;
   logic [NREG-1:0]       id_rs2;
   logic                  id_rs1_use;
   logic                  id_rs2_use;
   logic [NREG-1:0]       ex_rd;
   logic                  ex_is_load;
   logic                  ex_busy;
   logic                  if_wait;
   logic                  ma_wait;
   logic                  redirect;
   logic                  trap;
   logic                  trap_done;

   logic                  stall_pc;
   logic                  stall_fd;
   logic                  stall_de;
   logic                  stall_em;
   logic                  clear_fd;
   logic                  clear_de;
   logic                  clear_em;
   logic                  clear_mw;
   logic [PERF_CNT_W-1:0] perf_stall_cnt;
   logic [PERF_CNT_W-1:0] perf_flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_is_load,
             ex_busy, if_wait, ma_wait, redirect, trap, trap_done,
      input  stall_pc, stall_fd, stall_de, stall_em,
             clear_fd, clear_de, clear_em, clear_mw,
             perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_is_load,
             ex_busy, if_wait, ma_wait, redirect, trap, trap_done,
      output stall_pc, stall_fd, stall_de, stall_em,
             clear_fd, clear_de, clear_em, clear_mw,
             perf_stall_cnt, perf_flush_cnt
   );

endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard detection: the load in EX writes a register that the
// instruction in ID actually reads. x0 never creates a hazard.
module hazard_unit #(parameter int NREG = 5) (
   input  logic [NREG-1:0] id_rs1,
   input  logic [NREG-1:0] id_rs2,
   input  logic            id_rs1_use,
   input  logic            id_rs2_use,
   input  logic [NREG-1:0] ex_rd,
   input  logic            ex_is_load,
   output logic            lu
);

   logic [NREG-1:0] src_idx [2];
   logic            src_use [2];
   logic [1:0]      src_hit;

   assign src_idx[0] = id_rs1;
   assign src_idx[1] = id_rs2;
   assign src_use[0] = id_rs1_use;
   assign src_use[1] = id_rs2_use;

   // One comparator per source operand
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_use[gi] && (src_idx[gi] == ex_rd);
      end
   endgenerate

   assign lu = ex_is_load && (ex_rd != '0) && (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control: priority-encoded stalls, flush overrides, a
// small FSM that keeps flushing across fetch-wait and trap-entry windows,
// and optional performance counters (enabled with PIPE_CTRL_PERF_EN).
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int NREG = 5
) (
   input logic        clk,
   input logic        rst_n,
   pipe_ctrl_if.slave bus
);

   ctrl_state_t state_reg;
   pipe_ctl_t   ctl;
   logic        lu;
   logic        trap_acc;
   logic        redir_acc;

   hazard_unit #(.NREG(NREG)) u_hazard (
      .id_rs1     (bus.id_rs1),
      .id_rs2     (bus.id_rs2),
      .id_rs1_use (bus.id_rs1_use),
      .id_rs2_use (bus.id_rs2_use),
      .ex_rd      (bus.ex_rd),
      .ex_is_load (bus.ex_is_load),
      .lu         (lu)
   );

   // Control-flow events are only taken when MA is not waiting and no trap
   // entry is already in progress; the source holds them otherwise.
   assign trap_acc  = bus.trap     && !bus.ma_wait && (state_reg != TRAP_WAIT);
   assign redir_acc = bus.redirect && !bus.ma_wait && (state_reg != TRAP_WAIT);

   // Flush-hold FSM: trap beats redirect; REDIR_WAIT lasts until fetch is ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
      end else begin
         case (state_reg)
            RUN: begin
               if (trap_acc)
                  state_reg <= TRAP_WAIT;
               else if (redir_acc && bus.if_wait)
                  state_reg <= REDIR_WAIT;
            end
            REDIR_WAIT: begin
               if (trap_acc)
                  state_reg <= TRAP_WAIT;
               else if (!bus.if_wait)
                  state_reg <= RUN;
            end
            TRAP_WAIT: begin
               if (bus.trap_done)
                  state_reg <= RUN;
            end
            default: state_reg <= RUN;
         endcase
      end
   end

   // Stall priority, then flush overrides, then FSM holds, then reset forcing
   always_comb begin
      ctl = '0;

      if (bus.ma_wait) begin
         ctl.stall_pc = 1'b1;
         ctl.stall_fd = 1'b1;
         ctl.stall_de = 1'b1;
         ctl.stall_em = 1'b1;
         ctl.clear_mw = 1'b1;
      end else if (bus.ex_busy) begin
         ctl.stall_pc = 1'b1;
         ctl.stall_fd = 1'b1;
         ctl.stall_de = 1'b1;
         ctl.clear_em = 1'b1;
      end else if (lu) begin
         ctl.stall_pc = 1'b1;
         ctl.stall_fd = 1'b1;
         ctl.clear_de = 1'b1;
      end else if (bus.if_wait) begin
         ctl.stall_pc = 1'b1;
         ctl.clear_fd = 1'b1;
      end

      // Wrong-path entries are bubbled in the very cycle of the pulse
      if (trap_acc) begin
         ctl.clear_fd = 1'b1;
         ctl.clear_de = 1'b1;
         ctl.clear_em = 1'b1;
         ctl.stall_fd = 1'b0;
         ctl.stall_de = 1'b0;
         ctl.stall_em = 1'b0;
      end
      if (redir_acc) begin
         ctl.clear_fd = 1'b1;
         ctl.clear_de = 1'b1;
         ctl.stall_fd = 1'b0;
         ctl.stall_de = 1'b0;
      end

      // Hold flushes for an already accepted event until the window closes
      case (state_reg)
         REDIR_WAIT: begin
            ctl.clear_fd = 1'b1;
            ctl.stall_fd = 1'b0;
         end
         TRAP_WAIT: begin
            ctl.stall_pc = 1'b1;
            ctl.clear_fd = 1'b1;
            ctl.clear_de = 1'b1;
            ctl.clear_em = 1'b1;
            ctl.stall_fd = 1'b0;
            ctl.stall_de = 1'b0;
            ctl.stall_em = 1'b0;
         end
         default: ;
      endcase

      // Whole pipeline is bubbled while reset is asserted
      if (!rst_n) begin
         ctl          = '0;
         ctl.clear_fd = 1'b1;
         ctl.clear_de = 1'b1;
         ctl.clear_em = 1'b1;
         ctl.clear_mw = 1'b1;
      end
   end

   assign bus.stall_pc = ctl.stall_pc;
   assign bus.stall_fd = ctl.stall_fd;
   assign bus.stall_de = ctl.stall_de;
   assign bus.stall_em = ctl.stall_em;
   assign bus.clear_fd = ctl.clear_fd;
   assign bus.clear_de = ctl.clear_de;
   assign bus.clear_em = ctl.clear_em;
   assign bus.clear_mw = ctl.clear_mw;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] stall_cnt_reg;
   logic [PERF_CNT_W-1:0] flush_cnt_reg;
   logic                  flush_ev;

   // A simultaneous trap and redirect counts as a single flush
   assign flush_ev = trap_acc || redir_acc;

   // Saturating stall-cycle and flush-event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= sat_inc(stall_cnt_reg, ctl.stall_pc);
         flush_cnt_reg <= sat_inc(flush_cnt_reg, flush_ev);
      end
   end

   assign bus.perf_stall_cnt = stall_cnt_reg;
   assign bus.perf_flush_cnt = flush_cnt_reg;
`else
   assign bus.perf_stall_cnt = '0;
   assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control for the 5-stage core (IF, ID, EX, MA, WB). It generates the per-boundary `stall`/`clear` pairs consumed by the pipeline registers: PC, IF/ID (fd), ID/EX (de), EX/MA (em) and MA/WB (mw). Inputs are hazard sources (load-use, multicycle EX, fetch/data memory wait) and control-flow events (EX redirect, MA trap). A small FSM holds flushes across fetch-wait and trap-entry windows.

## Interface
- `NREG`, default 5, register-index width (x0..x31).
- `clk`, in, 1, core clock.
- `rst_n`, in, 1, reset, asynchronous, active-low.
- `id_rs1` / `id_rs2`, in, NREG each, source registers of the instruction in ID.
- `id_rs1_use` / `id_rs2_use`, in, 1 each, source actually read.
- `ex_rd`, in, NREG, destination register of the instruction in EX.
- `ex_is_load`, in, 1, instruction in EX is a load.
- `ex_busy`, in, 1, multicycle unit in EX is not done.
- `if_wait`, in, 1, instruction fetch not ready this cycle.
- `ma_wait`, in, 1, data memory access not complete.
- `redirect`, in, 1, EX-resolved branch/jump is taken (one-cycle pulse).
- `trap`, in, 1, exception/interrupt taken at MA (one-cycle pulse).
- `trap_done`, in, 1, CSR unit has installed the trap vector PC.
- `stall_pc`, `stall_fd`, `stall_de`, `stall_em`, out, 1 each, hold the register.
- `clear_fd`, `clear_de`, `clear_em`, `clear_mw`, out, 1 each, load bubble.
- `perf_stall_cnt`, `perf_flush_cnt`, out, 32 each, performance counters.

## Operation
- Load-use hazard `lu` = ex_is_load & ex_rd≠0 & ((id_rs1_use & id_rs1==ex_rd) | (id_rs2_use & id_rs2==ex_rd)).
- Priority, highest first; each level overrides the ones below it:
  - ma_wait: stall pc, fd, de, em; clear_mw.
  - ex_busy: stall pc, fd, de; clear_em.
  - lu: stall pc, fd; clear_de.
  - if_wait: stall pc; clear_fd.
- Flushes override stalls on the same register, except while ma_wait is high.
  - trap: clear fd, de, em.
  - redirect: clear fd, de.
- A clear and a stall on the same register are never both 1.
- FSM states: RUN, REDIR_WAIT, TRAP_WAIT.
  - RUN→TRAP_WAIT on trap & ~ma_wait. Trap wins over a simultaneous redirect.
  - RUN→REDIR_WAIT on redirect & if_wait & ~ma_wait.
  - A trap or redirect arriving during ma_wait is ignored. The source must hold it until ma_wait falls.
  - REDIR_WAIT: assert clear_fd and stall_fd=0 each cycle. Go to RUN on the first cycle with ~if_wait; clear_fd is still 1 in that cycle.
  - TRAP_WAIT: assert clear fd, de, em and stall_pc. Go to RUN on trap_done.
  - trap in REDIR_WAIT → TRAP_WAIT.
- Mid-operation reset returns the FSM to RUN immediately.

## Timing
- All stall/clear outputs are combinational from the inputs plus registered state, so they are valid in the same cycle.
- State and counters update on posedge clk.
- While rst_n is low, all clear_* are 1, all stall_* are 0, and the counters are 0.
- The first cycle after reset is in RUN.
- Redirect latency: the wrong-path fd/de entries are bubbled in the cycle of the redirect pulse.
- Trap latency: same rule, applied to em.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - perf_stall_cnt increments on each cycle with stall_pc=1.
  - perf_flush_cnt increments on each accepted redirect or trap.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `pipe_pkg` holds:
  - `ctrl_state_t` enum {RUN, REDIR_WAIT, TRAP_WAIT}.
  - Packed struct `pipe_ctl_t`, carrying stall/clear per boundary.
  - Constant `PERF_CNT_W`=32.
- One sub-module, `hazard_unit`, computes `lu`.
- The FSM, priority encode and counters stay in `pipe_ctrl`.

## Test plan
- id_rs1=5 (used), ex_rd=5, ex_is_load=1 → stall_pc=stall_fd=1 and clear_de=1 for one cycle. With ex_rd=0, no stall.
- ma_wait=1 for 3 cycles with lu=1 → stall pc/fd/de/em=1 and clear_mw=1 for 3 cycles, clear_de=0. perf_stall_cnt += 3 with the macro defined.
- redirect pulse with if_wait=1 for 2 cycles → FSM enters REDIR_WAIT. clear_fd=1 for 3 cycles, clear_de=1 in the pulse cycle only, then RUN.
- trap and redirect in the same cycle → TRAP_WAIT; clear fd/de/em held until trap_done, then RUN. perf_flush_cnt += 1.
- rst_n dropped while in TRAP_WAIT → all clear_*=1 and stall_*=0 asynchronously. After release, state is RUN and the counters are 0.
